// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser (uart_frame_rx / uart_frame_buf).
package uart_frame_pkg;

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHECK, DRAIN} frame_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic logic len_ok(input logic [7:0] len_byte, input int unsigned max_len);
    return (len_byte != 8'd0) && (32'(len_byte) <= max_len);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for uart_frame_rx: one synchronous write port, one combinational read port.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser behind the 8/N/1 UART receiver: SYNC, LEN, payload, CHK; good payload streamed out.
// Optional inter-byte timeout is compiled in with `define UART_FRAME_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | hunting for the sync byte
// LEN     | waiting for the length byte
// PAYLOAD | storing payload bytes into the buffer
// CHECK   | waiting for the checksum byte
// DRAIN   | streaming the buffered payload to the consumer
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CLKS = 5000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_busy,
  output logic       o_err_len,
  output logic       o_err_chk,
  output logic       o_err_timeout,
  output logic       o_overrun
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  frame_state_t state, state_nxt;
  logic [7:0] len, idx, rd_idx, sum;
  logic [7:0] rd_data, chk_sum;
  logic       len_good, wr_en, hs, timeout_hit;
  logic       err_len_nxt, err_chk_nxt, overrun_nxt;

  assign len_good = len_ok(i_data, MAX_LEN);
  assign chk_sum  = sum + i_data;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CLKS + 1);
  logic [GW-1:0] gap_cnt;
  logic          in_frame;

  assign in_frame    = (state == LEN) || (state == PAYLOAD) || (state == CHECK);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = in_frame && !i_valid && (gap_cnt == GW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || !in_frame || i_valid) gap_cnt <= '0;
    else                               gap_cnt <= gap_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (i_clk),
    .wr_en   (wr_en),
    .wr_addr (idx[AW-1:0]),
    .wr_data (i_data),
    .rd_addr (rd_idx[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_err_len     <= 1'b0;
      o_err_chk     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      state         <= state_nxt;
      o_err_len     <= err_len_nxt;
      o_err_chk     <= err_chk_nxt;
      o_err_timeout <= timeout_hit;
      o_overrun     <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid && i_data == SYNC_BYTE) state_nxt = LEN;
      LEN:     if (timeout_hit) state_nxt = IDLE;
               else if (i_valid) state_nxt = len_good ? PAYLOAD : IDLE;
      PAYLOAD: if (timeout_hit) state_nxt = IDLE;
               else if (i_valid && idx == len - 8'd1) state_nxt = CHECK;
      CHECK:   if (timeout_hit) state_nxt = IDLE;
               else if (i_valid) state_nxt = (chk_sum == 8'd0) ? DRAIN : IDLE;
      DRAIN:   if (hs && o_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_valid     = (state == DRAIN);
    o_data      = o_valid ? rd_data : 8'd0;
    o_last      = o_valid && (rd_idx == len - 8'd1);
    o_busy      = (state != IDLE);
    hs          = o_valid && i_ready;
    wr_en       = (state == PAYLOAD) && i_valid;
    err_len_nxt = (state == LEN) && i_valid && !len_good;
    err_chk_nxt = (state == CHECK) && i_valid && (chk_sum != 8'd0);
    overrun_nxt = (state == DRAIN) && i_valid;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len    <= 8'd0;
      idx    <= 8'd0;
      rd_idx <= 8'd0;
      sum    <= 8'd0;
    end else begin
      case (state)
        LEN:     if (i_valid && len_good) begin
                   len <= i_data;
                   sum <= i_data;
                   idx <= 8'd0;
                 end
        PAYLOAD: if (i_valid) begin
                   sum <= sum + i_data;
                   idx <= idx + 8'd1;
                 end
        CHECK:   if (i_valid) rd_idx <= 8'd0;
        DRAIN:   if (hs) rd_idx <= rd_idx + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomized self-checking bench for uart_frame_rx; expectations come from a frame-level model.
// Timeout expectations follow `define UART_FRAME_TIMEOUT_EN.
module tb_uart_frame_rx;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 50;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = 8'd0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_last, o_busy, o_err_len, o_err_chk, o_err_timeout, o_overrun;

  int n_checks = 0, n_fail = 0;
  int exp_len = 0, exp_chk = 0, exp_tmo = 0, exp_ovr = 0;
  int got_len = 0, got_chk = 0, got_tmo = 0, got_ovr = 0;
  int rdy_mode = 1;  // 0 random, 1 always ready, 2 stalled, 3 toggling

  logic [7:0] frm[$];
  logic [8:0] exp_q[$];

  uart_frame_rx #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TMO)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_last        (o_last),
    .o_busy        (o_busy),
    .o_err_len     (o_err_len),
    .o_err_chk     (o_err_chk),
    .o_err_timeout (o_err_timeout),
    .o_overrun     (o_overrun)
  );

  initial forever #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    #1;
    case (rdy_mode)
      0:       i_ready = 1'($urandom_range(0, 1));
      2:       i_ready = 1'b0;
      3:       i_ready = ~i_ready;
      default: i_ready = 1'b1;
    endcase
  end

  // Output monitor: pulse counting, stall stability, payload scoreboard.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic       prev_last = 1'b0;
  always @(negedge i_clk) begin : mon
    int pulses;
    logic [8:0] e;
    pulses = int'(o_err_len) + int'(o_err_chk) + int'(o_err_timeout) + int'(o_overrun);
    if (pulses != 0) check("pulse_excl", pulses, 1);
    got_len += int'(o_err_len);
    got_chk += int'(o_err_chk);
    got_tmo += int'(o_err_timeout);
    got_ovr += int'(o_overrun);
    if (prev_stall) begin
      check("stall_valid", o_valid, 1);
      check("stall_data", o_data, prev_data);
      check("stall_last", o_last, prev_last);
    end
    if (o_valid && i_ready && !i_rst) begin
      if (exp_q.size() == 0) check("unexpected_byte", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("payload_data", o_data, e[7:0]);
        check("payload_last", o_last, e[8]);
      end
    end
    prev_stall = o_valid && !i_ready && !i_rst;
    prev_data  = o_data;
    prev_last  = o_last;
  end

  // Frame-level reference: LEN range and modular checksum decide the outcome.
  task automatic model_frame();
    int l, s;
    if (frm.size() < 2 || frm[0] != 8'hA5) return;
    l = int'(frm[1]);
    if (l == 0 || l > MAX_LEN) begin
      exp_len++;
      return;
    end
    s = 0;
    for (int i = 1; i < frm.size(); i++) s += int'(frm[i]);
    if (s % 256 == 0)
      for (int i = 0; i < l; i++) exp_q.push_back({(i == l - 1), frm[2 + i]});
    else
      exp_chk++;
  endtask

  task automatic make_frame(input int l, input bit bad_chk);
    logic [7:0] s, p;
    frm.delete();
    frm.push_back(8'hA5);
    frm.push_back(8'(l));
    if (l == 0 || l > MAX_LEN) return;
    s = 8'(l);
    for (int i = 0; i < l; i++) begin
      p = 8'($urandom_range(0, 255));
      frm.push_back(p);
      s = s + p;
    end
    s = -s;
    if (bad_chk) s = s + 8'($urandom_range(1, 255));
    frm.push_back(s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk);
    #1;
    i_valid = 1'b1;
    i_data  = b;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    model_frame();
    foreach (frm[i]) begin
      send_byte(frm[i]);
      if (gap_max > 0 && i != frm.size() - 1) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic pulse_reset();
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_err_len"}, got_len, exp_len);
    check({tag, "_err_chk"}, got_chk, exp_chk);
    check({tag, "_err_tmo"}, got_tmo, exp_tmo);
    check({tag, "_overrun"}, got_ovr, exp_ovr);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (k < 3000 && (o_busy || exp_q.size() != 0)) begin
      @(negedge i_clk);
      k++;
    end
    check({tag, "_drained"}, (k < 3000), 1);
    repeat (2) @(negedge i_clk);
    check_counts(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, l;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_last", o_last, 0);
    check("rst_busy", o_busy, 0);
    check("rst_errs", {o_err_len, o_err_chk, o_err_timeout, o_overrun}, 0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Basic frame: latency and back-to-back output.
    rdy_mode = 1;
    frm = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_frame(0);
    @(negedge i_clk);
    check("t1_first_valid", o_valid, 1);
    check("t1_b0", o_data, 8'h11);
    check("t1_last0", o_last, 0);
    @(negedge i_clk);
    check("t1_b1", o_data, 8'h22);
    @(negedge i_clk);
    check("t1_b2", o_data, 8'h33);
    check("t1_last2", o_last, 1);
    wait_done("t1");

    // Noise then a one-byte frame.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    frm = '{8'hA5, 8'h01, 8'h7E, 8'h81};
    send_frame(0);
    wait_done("t2");

    // Bad checksum, then a good frame.
    frm = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_frame(0);
    wait_done("t3a");
    frm = '{8'hA5, 8'h01, 8'h05, 8'hFA};
    send_frame(0);
    wait_done("t3b");

    // LEN boundaries.
    make_frame(0, 0);           send_frame(0); wait_done("t4_zero");
    make_frame(MAX_LEN + 1, 0); send_frame(0); wait_done("t4_over");
    make_frame(MAX_LEN, 0);     send_frame(0); wait_done("t4_max");
    make_frame(1, 0);           send_frame(0); wait_done("t4_min");

    // Stall, overrun injection, then toggled ready.
    rdy_mode = 2;
    frm = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
    send_frame(0);
    idle(5);
    exp_ovr++;
    send_byte(8'hA5);
    idle(12);
    @(negedge i_clk);
    check("t5_stall_busy", o_busy, 1);
    check("t5_stall_valid", o_valid, 1);
    rdy_mode = 3;
    wait_done("t5");

    // Timeout behaviour depends on build.
    rdy_mode = 1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
`ifdef UART_FRAME_TIMEOUT_EN
    exp_tmo++;
    idle(TMO + 5);
    @(negedge i_clk);
    check("t6_busy_after_tmo", o_busy, 0);
`else
    idle(TMO + 5);
    @(negedge i_clk);
    check("t6_busy_no_tmo", o_busy, 1);
`endif
    pulse_reset();
    @(negedge i_clk);
    check("t6_busy_after_rst", o_busy, 0);
    check_counts("t6");

    // Reset mid-PAYLOAD.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    pulse_reset();
    @(negedge i_clk);
    check("t7_busy", o_busy, 0);
    make_frame(3, 0);
    send_frame(2);
    wait_done("t7");

    // Reset mid-DRAIN.
    rdy_mode = 2;
    make_frame(4, 0);
    send_frame(1);
    idle(3);
    pulse_reset();
    @(negedge i_clk);
    check("t8_valid_drop", o_valid, 0);
    check("t8_busy", o_busy, 0);
    exp_q.delete();
    check_counts("t8");

    // Random frames and noise with random backpressure.
    rdy_mode = 0;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        l = $urandom_range(0, 255);
        send_byte((8'(l) == 8'hA5) ? 8'h5A : 8'(l));
      end else begin
        if (kind == 1) l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        else           l = $urandom_range(1, MAX_LEN);
        make_frame(l, ($urandom_range(0, 3) == 0));
        send_frame(3);
      end
      wait_done("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
